// File: rtl/rvb_pkg.sv
// Shared types and default sizes for the fetch-side blocks.
package rvb_pkg;

  localparam int AW        = 32;
  localparam int DW        = 32;
  localparam int IFQ_DEPTH = 4;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [DW-1:0] ir;
    logic          filled;
  } ifq_entry_t;

endpackage

// File: rtl/ifq_ram.sv
// Fetch queue entry storage: pc written on allocate, ir+filled on fill, async read at head.
module ifq_ram
  import rvb_pkg::*;
#(
  parameter int DEPTH = IFQ_DEPTH,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             alloc_en,
  input  logic [PW-1:0]    alloc_idx,
  input  logic [AW-1:0]    alloc_pc,
  input  logic             fill_en,
  input  logic [PW-1:0]    fill_idx,
  input  logic [DW-1:0]    fill_ir,
  input  logic             deq_en,
  input  logic [PW-1:0]    deq_idx,
  input  logic [PW-1:0]    rd_idx,
  output ifq_entry_t       rd_entry,
  output logic [DEPTH-1:0] filled
);

  ifq_entry_t mem [DEPTH];

  // Clear is applied last so it wins over a fill or dequeue in the same cycle.
  always_ff @(posedge clk) begin
    if (alloc_en) mem[alloc_idx].pc <= alloc_pc;
    if (fill_en) begin
      mem[fill_idx].ir     <= fill_ir;
      mem[fill_idx].filled <= 1'b1;
    end
    if (deq_en) mem[deq_idx].filled <= 1'b0;
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) mem[i].filled <= 1'b0;
    end
  end

  always_comb begin
    filled = '0;
    for (int i = 0; i < DEPTH; i++) filled[i] = mem[i].filled;
  end

  assign rd_entry = mem[rd_idx];

endmodule

// File: rtl/ifq.sv
// Instruction fetch queue: credit-gated request pass-through, in-order fill, flush with stale-response drop.
module ifq #(
  parameter int AW    = rvb_pkg::AW,
  parameter int DW    = rvb_pkg::DW,
  parameter int DEPTH = rvb_pkg::IFQ_DEPTH
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ifu_req_vld,
  output logic          ifu_req_rdy,
  input  logic [AW-1:0] ifu_req_pc,
  output logic          biu_req_vld,
  input  logic          biu_req_rdy,
  output logic [AW-1:0] biu_req_pc,
  input  logic          biu_rsp_vld,
  output logic          biu_rsp_rdy,
  input  logic [DW-1:0] biu_rsp_inst,
  output logic          exu_req_vld,
  input  logic          exu_req_rdy,
  output logic [DW-1:0] exu_req_ir,
  output logic [AW-1:0] exu_req_pc,
  input  logic          flush
);
  import rvb_pkg::*;

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0]    head, tail, fill;
  logic [CW-1:0]    alloc_cnt, stale_cnt, filled_cnt;
  logic [DEPTH-1:0] filled;
  ifq_entry_t       head_entry;
  logic             credit, req_fire, rsp_fire, rsp_drop, rsp_write, deq;

  assign credit = ({1'b0, alloc_cnt} + {1'b0, stale_cnt}) < (CW+1)'(DEPTH);

  assign ifu_req_rdy = biu_req_rdy & credit;
  assign biu_req_vld = ifu_req_vld & credit;
  assign biu_req_pc  = ifu_req_pc;
  assign biu_rsp_rdy = 1'b1;

  assign exu_req_vld = head_entry.filled & ~flush & ~rst;
  assign exu_req_ir  = head_entry.ir;
  assign exu_req_pc  = head_entry.pc;

  assign req_fire  = biu_req_vld & biu_req_rdy;
  assign rsp_fire  = biu_rsp_vld;
  assign rsp_drop  = stale_cnt != '0;
  assign rsp_write = rsp_fire & ~rsp_drop & ~flush;
  assign deq       = exu_req_vld & exu_req_rdy;

  always_comb begin
    filled_cnt = '0;
    for (int i = 0; i < DEPTH; i++) filled_cnt = filled_cnt + CW'(filled[i]);
  end

  // Outstanding old-path requests become stale on flush; a same-cycle response consumes one of them.
  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      fill      <= '0;
      alloc_cnt <= '0;
      stale_cnt <= '0;
    end else if (flush) begin
      head      <= '0;
      fill      <= '0;
      tail      <= req_fire ? PW'(1) : '0;
      alloc_cnt <= CW'(req_fire);
      stale_cnt <= stale_cnt + alloc_cnt - filled_cnt - CW'(rsp_fire);
    end else begin
      if (req_fire)  tail <= tail + PW'(1);
      if (deq)       head <= head + PW'(1);
      if (rsp_write) fill <= fill + PW'(1);
      alloc_cnt <= alloc_cnt + CW'(req_fire) - CW'(deq);
      if (rsp_fire && rsp_drop) stale_cnt <= stale_cnt - CW'(1);
    end
  end

  ifq_ram #(.DEPTH(DEPTH)) u_ram (
    .clk       (clk),
    .clr       (rst | flush),
    .alloc_en  (req_fire & ~rst),
    .alloc_idx (flush ? '0 : tail),
    .alloc_pc  (ifu_req_pc),
    .fill_en   (rsp_write & ~rst),
    .fill_idx  (fill),
    .fill_ir   (biu_rsp_inst),
    .deq_en    (deq & ~rst),
    .deq_idx   (head),
    .rd_idx    (head),
    .rd_entry  (head_entry),
    .filled    (filled)
  );

endmodule
